// File: rtl/mips_pipe_scoreboard_if.sv
// Decode-side hazard/forwarding bundle between the MIPS pipeline and its scoreboard.
// MIPS_SB_STATS_EN adds the stall/flush cycle counters.
interface mips_pipe_scoreboard_if #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_dst;
    logic              id_is_load;
    logic              flush;
    logic              stall_if;
    logic              stall_d;
    logic              bubble_x;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              busy;
`ifdef MIPS_SB_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_dst, id_is_load, flush,
`ifdef MIPS_SB_STATS_EN
        input  stall_cnt, flush_cnt,
`endif
        input  stall_if, stall_d, bubble_x, fwd_rs_sel, fwd_rt_sel, busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_dst, id_is_load, flush,
`ifdef MIPS_SB_STATS_EN
        output stall_cnt, flush_cnt,
`endif
        output stall_if, stall_d, bubble_x, fwd_rs_sel, fwd_rt_sel, busy
    );
endinterface

// File: rtl/mips_pipe_scoreboard.sv
// Hazard/forwarding scoreboard: FWD_DEPTH-slot shift pipeline of in-flight writes (slot 0 = X).
// MIPS_SB_STATS_EN adds saturating stall/flush cycle counters.
module mips_pipe_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_pipe_scoreboard_if.slave sb
);
    typedef logic [FWD_DEPTH-1:0][REG_AW-1:0] dst_arr_t;

    logic [FWD_DEPTH-1:0] vld_q, vld_d, load_q, load_d;
    dst_arr_t             dst_q, dst_d;
    logic                 rs_hit, rs_rdy, rt_hit, rt_rdy, stall;
    logic [SEL_W-1:0]     rs_sel, rt_sel;

    // Scan oldest to youngest so the youngest match is what remains.
    // A load is forwardable once its select exceeds LOAD_LAT.
    function automatic void lookup(
        input  logic                 use_src,
        input  logic [REG_AW-1:0]    src,
        input  logic [FWD_DEPTH-1:0] vld,
        input  logic [FWD_DEPTH-1:0] load,
        input  dst_arr_t             dst,
        output logic                 hit,
        output logic                 rdy,
        output logic [SEL_W-1:0]     sel
    );
        hit = 1'b0;
        rdy = 1'b1;
        sel = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (use_src && src != '0 && vld[k] && dst[k] == src) begin
                hit = 1'b1;
                rdy = !load[k] || (k >= LOAD_LAT);
                sel = SEL_W'(k + 1);
            end
        end
    endfunction

    always_comb begin
        lookup(sb.id_use_rs, sb.id_rs, vld_q, load_q, dst_q, rs_hit, rs_rdy, rs_sel);
        lookup(sb.id_use_rt, sb.id_rt, vld_q, load_q, dst_q, rt_hit, rt_rdy, rt_sel);
        stall = sb.id_valid && ((rs_hit && !rs_rdy) || (rt_hit && !rt_rdy));

        sb.stall_if   = stall && !sb.flush;
        sb.stall_d    = stall && !sb.flush;
        sb.bubble_x   = stall || sb.flush;
        sb.fwd_rs_sel = sb.id_valid ? rs_sel : '0;
        sb.fwd_rt_sel = sb.id_valid ? rt_sel : '0;
        sb.busy       = |vld_q;

        vld_d     = vld_q << 1;
        load_d    = load_q << 1;
        dst_d     = dst_q << REG_AW;
        vld_d[0]  = sb.id_valid && sb.id_wr_en && !stall && !sb.flush;
        load_d[0] = sb.id_is_load;
        dst_d[0]  = sb.id_dst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= '0;
            load_q <= '0;
            dst_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            load_q <= load_d;
            dst_q  <= dst_d;
        end
    end

`ifdef MIPS_SB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (sb.stall_if && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        if (sb.flush && flush_cnt_q != 16'hFFFF)    flush_cnt_d = flush_cnt_q + 16'd1;
        sb.stall_cnt = stall_cnt_q;
        sb.flush_cnt = flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif
endmodule
